ahb_crypto_slave_fifo: RTL and testbench

- Parametrised AHB-Lite write-slave front end for the crypto module; next generation of the existing AHB slave.
- Decodes HADDR offsets into key, SRAM-address and data beats, and enforces packet ordering (key → address → data).
- Buffers key/data beats in an internal FIFO toward the cipher core and stalls the bus with HREADYOUT when full.
- Returns a proper two-cycle AHB ERROR response on reads and on out-of-order writes.

---
 rtl/crypto_ahb_pkg.sv | 33 +++
 rtl/sync_fifo.sv | 51 +++++
 rtl/ahb_crypto_slave_fifo.sv | 140 ++++++++++++++
 tb/tb_ahb_crypto_slave_fifo.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crypto_ahb_pkg.sv
// Shared types and constants for the AHB crypto write slave.
// Packet states, HADDR offset codes and HTRANS encodings.
package crypto_ahb_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEY,
        S_ADDR,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_e;

    localparam logic [1:0] OFF_KEY  = 2'b00;
    localparam logic [1:0] OFF_ADDR = 2'b01;
    localparam logic [1:0] OFF_DATA = 2'b10;
    localparam logic [1:0] OFF_LAST = 2'b11;

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_BUSY   = 2'b01;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;

    function automatic logic off_legal(input state_e st, input logic [1:0] off);
        case (st)
            S_IDLE, S_KEY: off_legal = (off == OFF_KEY);
            S_ADDR:        off_legal = (off == OFF_ADDR);
            S_DATA:        off_legal = off[1];
            default:       off_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered head, occupancy count and
// power-of-two wrapping pointers.
module sync_fifo #(
    parameter int WIDTH = 130,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    // Payload storage needs no reset; emptiness is tracked by the count.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end

endmodule

// File: rtl/ahb_crypto_slave_fifo.sv
// AHB-Lite write slave: key/address/data packet sequencing, FIFO
// buffering toward the cipher core, two-cycle ERROR responses.
module ahb_crypto_slave_fifo
    import crypto_ahb_pkg::*;
#(
    parameter int DATA_W     = 128,
    parameter int ADDR_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int KEY_BEATS  = 1
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          HSELx,
    input  logic [1:0]                    HTRANS,
    input  logic                          HWRITE,
    input  logic                          HREADY,
    input  logic [ADDR_W-1:0]             HADDR,
    input  logic [DATA_W-1:0]             HWDATA,
    output logic                          HREADYOUT,
    output logic                          HRESP,
    output logic [DATA_W-1:0]             out_data,
    output logic                          out_is_key,
    output logic                          out_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ADDR_W-1:0]             sram_addr,
    output logic                          addr_valid,
    output logic                          pkt_idle,
    output logic                          pkt_abort,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int KCW = $clog2(KEY_BEATS + 1);

    state_e            r_state;
    state_e            w_state_after;
    state_e            w_state_nxt;
    logic              r_dp_valid;
    logic [1:0]        r_dp_off;
    logic [KCW-1:0]    r_key_cnt;
    logic [KCW-1:0]    w_key_cnt_nxt;
    logic [KCW-1:0]    w_key_inc;
    logic [ADDR_W-1:0] r_sram_addr;
    logic              r_addr_valid;
    logic              w_full;
    logic              w_empty;
    logic              w_need_push;
    logic              w_stall;
    logic              w_done;
    logic              w_accept;
    logic              w_legal;
    logic              w_addr_wr;
    logic [DATA_W+1:0] w_fifo_in;
    logic [DATA_W+1:0] w_fifo_out;
    logic              w_unused;

    assign w_need_push = r_dp_valid && (r_dp_off != OFF_ADDR);
    assign w_stall     = w_need_push && w_full;
    assign w_done      = r_dp_valid && !w_stall;
    assign w_addr_wr   = w_done && (r_dp_off == OFF_ADDR);
    assign w_accept    = HSELx && HREADY && HTRANS[1];
    assign w_key_inc   = r_key_cnt + KCW'(1);
    assign w_unused    = ^{HADDR[ADDR_W-1:4], HADDR[1:0], HTRANS[0]};

    // Legality is judged against the state the current beat leaves behind.
    assign w_legal = HWRITE && off_legal(w_state_after, HADDR[3:2]);

    always_comb begin
        w_state_after = r_state;
        w_key_cnt_nxt = r_key_cnt;
        case (r_state)
            S_IDLE: if (w_done) begin
                w_state_after = (KEY_BEATS == 1) ? S_ADDR : S_KEY;
                w_key_cnt_nxt = KCW'(1);
            end
            S_KEY: if (w_done) begin
                w_key_cnt_nxt = w_key_inc;
                if (w_key_inc == KCW'(KEY_BEATS)) w_state_after = S_ADDR;
            end
            S_ADDR: if (w_done) w_state_after = S_DATA;
            S_DATA: if (w_done && r_dp_off == OFF_LAST) w_state_after = S_IDLE;
            S_ERR1: w_state_after = S_ERR2;
            S_ERR2: w_state_after = S_IDLE;
            default: w_state_after = S_IDLE;
        endcase
        w_state_nxt = w_state_after;
        if (w_accept && !w_legal) w_state_nxt = S_ERR1;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state      <= S_IDLE;
            r_key_cnt    <= '0;
            r_dp_valid   <= 1'b0;
            r_dp_off     <= OFF_KEY;
            r_sram_addr  <= '0;
            r_addr_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_key_cnt    <= w_key_cnt_nxt;
            r_addr_valid <= w_addr_wr;
            if (w_addr_wr) r_sram_addr <= HWDATA[ADDR_W-1:0];
            if (w_accept) begin
                r_dp_valid <= w_legal;
                r_dp_off   <= HADDR[3:2];
            end else if (w_done) begin
                r_dp_valid <= 1'b0;
            end
        end
    end

    assign w_fifo_in = {r_dp_off == OFF_KEY, r_dp_off == OFF_LAST, HWDATA};

    sync_fifo #(
        .WIDTH (DATA_W + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .n_rst   (n_rst),
        .i_push  (w_need_push),
        .i_data  (w_fifo_in),
        .i_pop   (out_ready),
        .o_data  (w_fifo_out),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );

    assign HREADYOUT  = (r_state != S_ERR1) && !w_stall;
    assign HRESP      = (r_state == S_ERR1) || (r_state == S_ERR2);
    assign out_data   = w_fifo_out[DATA_W-1:0];
    assign out_last   = w_fifo_out[DATA_W];
    assign out_is_key = w_fifo_out[DATA_W+1];
    assign out_valid  = !w_empty;
    assign sram_addr  = r_sram_addr;
    assign addr_valid = r_addr_valid;
    assign pkt_idle   = (r_state == S_IDLE);
    assign pkt_abort  = (r_state == S_ERR1);

endmodule

// File: tb/tb_ahb_crypto_slave_fifo.sv
// Bench for ahb_crypto_slave_fifo: transaction-level model with a
// per-cycle compare, plus directed literal checks.
module tb_ahb_crypto_slave_fifo;
    import crypto_ahb_pkg::*;

    localparam int DW    = 128;
    localparam int AW    = 32;
    localparam int DEPTH = 4;
    localparam int KB    = 1;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          HSELx = 1'b0;
    logic [1:0]    HTRANS = HT_IDLE;
    logic          HWRITE = 1'b0;
    logic          HREADY;
    logic [AW-1:0] HADDR = '0;
    logic [DW-1:0] HWDATA = '0;
    logic          HREADYOUT, HRESP;
    logic [DW-1:0] out_data;
    logic          out_is_key, out_last, out_valid;
    logic          out_ready = 1'b0;
    logic [AW-1:0] sram_addr;
    logic          addr_valid, pkt_idle, pkt_abort;
    logic [2:0]    fifo_count;

    assign HREADY = HREADYOUT;

    ahb_crypto_slave_fifo #(
        .DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .KEY_BEATS(KB)
    ) dut (
        .clk(clk), .n_rst(n_rst), .HSELx(HSELx), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HREADY(HREADY), .HADDR(HADDR),
        .HWDATA(HWDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
        .out_data(out_data), .out_is_key(out_is_key),
        .out_last(out_last), .out_valid(out_valid),
        .out_ready(out_ready), .sram_addr(sram_addr),
        .addr_valid(addr_valid), .pkt_idle(pkt_idle),
        .pkt_abort(pkt_abort), .fifo_count(fifo_count)
    );

    initial forever #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: queue of expected FIFO contents plus packet position.
    logic [DW+1:0] q[$];
    logic [DW+1:0] pop_log[$];
    bit            m_dp = 0;
    logic [1:0]    m_off = OFF_KEY;
    int            m_err = 0;
    int            m_keys = 0;
    bit            m_have_addr = 0;
    bit            m_apulse = 0;
    logic [AW-1:0] m_sram = '0;

    task automatic chk(input string nm, input logic [DW+1:0] act,
                       input logic [DW+1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int  sz;
        bit  stall, done, hrdy, legal;
        logic [1:0] off;
        if (!n_rst) begin
            q.delete();
            m_dp = 0; m_err = 0; m_keys = 0; m_have_addr = 0;
            m_apulse = 0; m_sram = '0;
            return;
        end
        sz    = q.size();
        stall = m_dp && (m_off != OFF_ADDR) && (sz == DEPTH);
        done  = m_dp && !stall;
        hrdy  = (m_err != 2) && !stall;
        m_apulse = 0;
        if (out_ready && sz > 0) void'(q.pop_front());
        if (done) begin
            if (m_off == OFF_KEY) begin
                q.push_back({2'b10, HWDATA});
                m_keys++;
            end else if (m_off == OFF_ADDR) begin
                m_sram = HWDATA[AW-1:0];
                m_apulse = 1;
                m_have_addr = 1;
            end else if (m_off == OFF_DATA) begin
                q.push_back({2'b00, HWDATA});
            end else begin
                q.push_back({2'b01, HWDATA});
                m_keys = 0;
                m_have_addr = 0;
            end
        end
        if (m_err > 0) m_err--;
        if (HSELx && hrdy && HTRANS[1]) begin
            off = HADDR[3:2];
            if (off == OFF_KEY)       legal = !m_have_addr && m_keys < KB;
            else if (off == OFF_ADDR) legal = !m_have_addr && m_keys == KB;
            else                      legal = m_have_addr;
            legal = legal && HWRITE;
            m_dp  = legal;
            m_off = off;
            if (!legal) begin
                m_err = 2; m_keys = 0; m_have_addr = 0;
            end
        end else if (done) begin
            m_dp = 0;
        end
    endtask

    task automatic compare();
        bit stall;
        stall = m_dp && (m_off != OFF_ADDR) && (q.size() == DEPTH);
        chk("hreadyout", HREADYOUT, (m_err != 2) && !stall);
        chk("hresp", HRESP, m_err != 0);
        chk("fifo_count", fifo_count, q.size());
        chk("out_valid", out_valid, q.size() > 0);
        if (q.size() > 0) chk("head", {out_is_key, out_last, out_data}, q[0]);
        chk("sram_addr", sram_addr, m_sram);
        chk("addr_valid", addr_valid, m_apulse);
        chk("pkt_idle", pkt_idle, m_err == 0 && m_keys == 0 && !m_have_addr);
        chk("pkt_abort", pkt_abort, m_err == 2);
        if (out_valid && out_ready) pop_log.push_back({out_is_key, out_last, out_data});
    endtask

    initial forever begin
        @(posedge clk or negedge n_rst);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        compare();
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic step_until_ready(input string nm);
        bit r;
        int n;
        r = 0;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            r = HREADY;
            @(posedge clk);
            #2;
            if (r) break;
        end
        chk({nm, " timeout"}, r, 1'b1);
    endtask

    task automatic addr_phase(input logic [1:0] tr, input logic w, input logic [3:0] a);
        HSELx  = 1'b1;
        HTRANS = tr;
        HWRITE = w;
        HADDR  = {28'h0, a};
        step_until_ready("addr");
        HSELx  = 1'b0;
        HTRANS = HT_IDLE;
        HWRITE = 1'b0;
    endtask

    task automatic data_phase(input logic [DW-1:0] d);
        HWDATA = d;
        step_until_ready("data");
    endtask

    task automatic wr(input logic [3:0] a, input logic [DW-1:0] d);
        addr_phase(HT_NONSEQ, 1'b1, a);
        data_phase(d);
    endtask

    task automatic err_seq(input string nm);
        @(negedge clk);
        chk({nm, " e1 hreadyout"}, HREADYOUT, 1'b0);
        chk({nm, " e1 hresp"}, HRESP, 1'b1);
        chk({nm, " e1 abort"}, pkt_abort, 1'b1);
        @(posedge clk); #2;
        @(negedge clk);
        chk({nm, " e2 hreadyout"}, HREADYOUT, 1'b1);
        chk({nm, " e2 hresp"}, HRESP, 1'b1);
        chk({nm, " e2 abort"}, pkt_abort, 1'b0);
        @(posedge clk); #2;
    endtask

    localparam logic [DW-1:0] K  = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    localparam logic [DW-1:0] D0 = 128'hd0d0d0d0_11111111_22222222_33333333;
    localparam logic [DW-1:0] D1 = 128'hd1d1d1d1_44444444_55555555_66666666;

    initial begin
        @(posedge clk); #2;
        idle(2);
        chk("rst hreadyout", HREADYOUT, 1'b1);
        chk("rst hresp", HRESP, 1'b0);
        chk("rst count", fifo_count, 3'd0);
        chk("rst valid", out_valid, 1'b0);
        chk("rst idle", pkt_idle, 1'b1);
        chk("rst sram", sram_addr, 32'h0);
        n_rst = 1'b1;
        idle(2);

        // nominal packet
        out_ready = 1'b1;
        pop_log.delete();
        wr(4'h0, K);
        wr(4'h4, 128'h100);
        chk("nom addr_valid", addr_valid, 1'b1);
        chk("nom sram_addr", sram_addr, 32'h100);
        wr(4'h8, D0);
        wr(4'hC, D1);
        idle(3);
        chk("nom pops", pop_log.size(), 3);
        if (pop_log.size() == 3) begin
            chk("nom pop0", pop_log[0], {2'b10, K});
            chk("nom pop1", pop_log[1], {2'b00, D0});
            chk("nom pop2", pop_log[2], {2'b01, D1});
        end
        chk("nom idle", pkt_idle, 1'b1);

        // backpressure
        out_ready = 1'b0;
        pop_log.delete();
        wr(4'h0, 128'hA5);
        wr(4'h4, 128'h200);
        wr(4'h8, 128'hA0);
        wr(4'h8, 128'hA1);
        wr(4'h8, 128'hA2);
        addr_phase(HT_NONSEQ, 1'b1, 4'hC);
        HWDATA = 128'hA3;
        @(negedge clk);
        chk("bp stall hreadyout", HREADYOUT, 1'b0);
        chk("bp stall count", fifo_count, 3'd4);
        @(posedge clk); #2;
        out_ready = 1'b1;
        @(posedge clk); #2;
        out_ready = 1'b0;
        @(negedge clk);
        chk("bp release", HREADYOUT, 1'b1);
        step_until_ready("bp data3");
        chk("bp count after", fifo_count, 3'd4);
        out_ready = 1'b1;
        idle(6);
        chk("bp pops", pop_log.size(), 5);
        if (pop_log.size() == 5) begin
            chk("bp pop0", pop_log[0], {2'b10, 128'hA5});
            chk("bp pop3", pop_log[3], {2'b00, 128'hA2});
            chk("bp pop4", pop_log[4], {2'b01, 128'hA3});
        end

        // order violation in S_IDLE
        out_ready = 1'b0;
        addr_phase(HT_NONSEQ, 1'b1, 4'h8);
        HWDATA = 128'hBAD;
        err_seq("order");
        chk("order count", fifo_count, 3'd0);
        chk("order idle", pkt_idle, 1'b1);

        // read in S_DATA, then fresh key
        out_ready = 1'b1;
        pop_log.delete();
        wr(4'h0, 128'hC3);
        wr(4'h4, 128'h300);
        wr(4'h8, 128'hB0);
        addr_phase(HT_NONSEQ, 1'b0, 4'h8);
        err_seq("read");
        wr(4'h0, 128'hC4);
        chk("read newkey idle", pkt_idle, 1'b0);
        wr(4'h4, 128'h340);
        chk("read sram", sram_addr, 32'h340);
        wr(4'hC, 128'hB1);
        idle(3);
        chk("read pops", pop_log.size(), 4);
        if (pop_log.size() == 4) chk("read key2", pop_log[2], {2'b10, 128'hC4});

        // BUSY interleave and simultaneous push/pop
        out_ready = 1'b0;
        wr(4'h0, 128'hC5);
        wr(4'h4, 128'h400);
        wr(4'h8, 128'hE0);
        addr_phase(HT_BUSY, 1'b1, 4'h8);
        idle(1);
        chk("busy count", fifo_count, 3'd2);
        chk("busy hresp", HRESP, 1'b0);
        addr_phase(HT_NONSEQ, 1'b1, 4'h8);
        out_ready = 1'b1;
        data_phase(128'hE1);
        out_ready = 1'b0;
        chk("pushpop count", fifo_count, 3'd2);
        wr(4'h8, 128'hE2);

        // async reset during an error stall with 3 entries
        addr_phase(HT_NONSEQ, 1'b0, 4'h0);
        #1;
        chk("prerst count", fifo_count, 3'd3);
        chk("prerst hreadyout", HREADYOUT, 1'b0);
        n_rst = 1'b0;
        #1;
        chk("arst hreadyout", HREADYOUT, 1'b1);
        chk("arst hresp", HRESP, 1'b0);
        chk("arst count", fifo_count, 3'd0);
        chk("arst valid", out_valid, 1'b0);
        chk("arst idle", pkt_idle, 1'b1);
        chk("arst abort", pkt_abort, 1'b0);
        chk("arst sram", sram_addr, 32'h0);
        @(posedge clk); #2;
        n_rst = 1'b1;
        idle(2);
        wr(4'h0, 128'hC6);
        idle(2);
        chk("post count", fifo_count, 3'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
